muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle RV32M multiply/divide controller that executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU by sequencing the shared 32-bit `alu` (ADD, SUB, XOR). It sits beside the execute stage and takes one request at a time over a valid/ready handshake. While busy it owns the ALU operand/opcode mux. Results return over a valid/ready response channel.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_op` in 3: RV32M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
- `req_a`, `req_b` in 32: rs1, rs2.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_data` out 32: result.
- `rsp_err` out 1: unsupported op; see Configuration.
- `busy` out 1: high in any state other than IDLE.
- `alu_operand_a`, `alu_operand_b` out 32: drive the ALU.
- `alu_op` out 4: drives the ALU; ADD=0000, SUB=0001, XOR=0100.
- `alu_result` in 32: combinational ALU result, same cycle.
- `alu_carry` in 1: ALU carry_flag. Carry-out on ADD; borrow on SUB (1 iff a<b unsigned).

## Operation
- States: IDLE, NEG_A, NEG_B, ITER, FIX_LO, FIX_HI, DONE.
- Accept on `req_valid & req_ready`. Latch op, the operands, and the flags sa/sb (operand sign, for signed operand positions only). Then go to the first applicable state of NEG_A, NEG_B, ITER.
- NEG_A/NEG_B: operand := ALU SUB(0, operand).
- ITER runs 32 cycles; a 5-bit count goes 31→0.
- Multiply: hi=0, lo=multiplier, mcand=multiplicand.
  - ALU ADD(hi, lo[0] ? mcand : 0).
  - {hi,lo} := {alu_carry, alu_result, lo[31:1]} >> 0.
  - That is: hi={carry,res[31:1]}, lo={res[0],lo[31:1]}.
- Divide (restoring): rem=0, quo=dividend, s={rem,quo[31]} (33 bits).
  - ALU SUB(s[31:0], divisor).
  - If s[32] | ~alu_carry: rem:=alu_result, quo:={quo[30:0],1}.
  - Else: rem:=s[31:0], quo:={quo[30:0],0}.
- Sign fix, applied after ITER:
  - MULH: negate the 64-bit product if sa^sb. MULHSU: negate if sa. MUL and MULHU: never.
  - FIX_LO: lo := SUB(0, lo). Record z = (original lo == 0).
  - FIX_HI: hi := z ? SUB(0, hi) : XOR(hi, 32'hFFFFFFFF).
  - DIV: quotient negated if sa^sb, via FIX_LO only.
  - REM: remainder negated if sa, via FIX_LO only.
- Result select: MUL → lo; MULH* → hi; DIV/DIVU → quo; REM/REMU → rem.
- Special cases are resolved at accept and go directly to DONE:
  - Divisor 0: quotient = 0xFFFFFFFF, remainder = dividend.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- DONE: `rsp_valid`=1 and `rsp_data` held stable until `rsp_ready`, then IDLE.
- ALU drive outside NEG/ITER/FIX: operands 0, op ADD.

## Timing
- Reset values: state IDLE; `req_ready`=1; `rsp_valid`=0; `rsp_data`=0; `rsp_err`=0; `busy`=0; `alu_*`=0. All internal registers are 0.
- Accept edge E0. `rsp_valid` first sampled high at E0+33+n, where n = count of NEG_A, NEG_B, FIX_LO, FIX_HI visited (0–4).
- Special cases and `rsp_err` cases: `rsp_valid` at E0+1.
- No accept in DONE, even when `rsp_ready`=1. The earliest next accept is 1 cycle after the response handshake.
- Throughput: at most one operation in flight.
- `rsp_ready` is ignored when `rsp_valid`=0.
- `rst_n` low at any time, including mid-ITER: immediate return to the reset values. The in-flight operation is discarded and no response is produced.

## Configuration
- `MULDIV_DIV_EN` defined: all eight ops are executed as above.
- `MULDIV_DIV_EN` undefined: the divider path, the rem/quo logic and the special-case detection are not built.
  - Ops 100–111 complete at E0+1 with `rsp_data`=0 and `rsp_err`=1.
  - Multiply ops are unchanged.

## Structure
- Shared package `riscv_pkg` holds:
  - ALU opcode constants (OP_ADD..OP_SLTU).
  - MULDIV funct3 constants.
  - The sequencer state enum.
- Sub-module `muldiv_iter_dp` holds the hi/lo, rem/quo and count registers plus the per-iteration update logic. `muldiv_sequencer` keeps the FSM, the handshakes and the ALU mux.

## Test plan
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MUL with the same operands → 0x00000001; both at E0+33.
- MUL 0xFFFFFFFD × 7 → 0xFFFFFFEB at E0+33. MULH with the same operands → 0xFFFFFFFF at E0+36. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD at E0+35. REM with the same operands → 0xFFFFFFFF. DIVU 0x80000000 / 3 → 0x2AAAAAAA.
- Each at E0+1:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in DONE → `rsp_valid` and `rsp_data` stable, `req_ready`=0. Accept occurs the cycle after the handshake.
- Assert `rst_n` at ITER count 10 → all outputs return to the reset values asynchronously. After release, MULHU 0x10000 × 0x10000 → 0x00000001. Without `MULDIV_DIV_EN`: DIVU 5/0 → `rsp_data`=0, `rsp_err`=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: ALU opcodes, RV32M funct3 codes and the muldiv sequencer states.
// MULDIV_DIV_EN (used by the muldiv files) selects whether the divide ops are built.
package riscv_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NEG_A  = 3'd1,
        ST_NEG_B  = 3'd2,
        ST_ITER   = 3'd3,
        ST_FIX_LO = 3'd4,
        ST_FIX_HI = 3'd5,
        ST_DONE   = 3'd6
    } md_state_e;

    // High-word multiplies and remainders return the hi/rem register; the rest return lo/quo.
    function automatic logic f3_sel_hi(input logic [2:0] f3);
        return (!f3[2] && (f3 != F3_MUL)) || (f3[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// Iteration datapath for muldiv_sequencer: hi/rem, lo/quo, operand and count registers.
// The restoring-divide update is only built with MULDIV_DIV_EN.
module muldiv_iter_dp #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_hi_init,
    input  logic [XLEN-1:0] i_lo_init,
    input  logic [XLEN-1:0] i_mcand_init,
    input  logic            i_neg_a,
    input  logic            i_neg_b,
    input  logic            i_iter,
`ifdef MULDIV_DIV_EN
    input  logic            i_is_div,
`endif
    input  logic            i_fix_lo,
    input  logic            i_fix_rem,
    input  logic            i_fix_hi,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic            i_alu_carry,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo,
    output logic [XLEN-1:0] o_mcand,
    output logic [4:0]      o_cnt,
    output logic            o_z
);

    logic [XLEN-1:0] r_hi, r_lo, r_mcand;
    logic [4:0]      r_cnt;
    logic            r_z;
    logic [XLEN-1:0] w_hi_nxt, w_lo_nxt;
`ifdef MULDIV_DIV_EN
    logic            w_quo_bit;
`endif

    always_comb begin
        w_hi_nxt = {i_alu_carry, i_alu_result[XLEN-1:1]};
        w_lo_nxt = {i_alu_result[0], r_lo[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
        w_quo_bit = r_hi[XLEN-1] | ~i_alu_carry;
        if (i_is_div) begin
            // 33-bit partial remainder {r_hi, r_lo[MSB]}; its top bit forces a subtract.
            w_hi_nxt = w_quo_bit ? i_alu_result : {r_hi[XLEN-2:0], r_lo[XLEN-1]};
            w_lo_nxt = {r_lo[XLEN-2:0], w_quo_bit};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
            r_z     <= 1'b0;
        end else if (i_load) begin
            r_hi    <= i_hi_init;
            r_lo    <= i_lo_init;
            r_mcand <= i_mcand_init;
            r_cnt   <= 5'd31;
            r_z     <= 1'b0;
        end else if (i_neg_a) begin
            r_lo <= i_alu_result;
        end else if (i_neg_b) begin
            r_mcand <= i_alu_result;
        end else if (i_iter) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt - 5'd1;
        end else if (i_fix_lo) begin
            if (i_fix_rem) r_hi <= i_alu_result;
            else           r_lo <= i_alu_result;
            r_z <= (r_lo == '0);
        end else if (i_fix_hi) begin
            r_hi <= i_alu_result;
        end
    end

    assign o_hi    = r_hi;
    assign o_lo    = r_lo;
    assign o_mcand = r_mcand;
    assign o_cnt   = r_cnt;
    assign o_z     = r_z;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide controller that time-shares the execute-stage ALU (ADD/SUB/XOR).
// Define MULDIV_DIV_EN to build DIV/DIVU/REM/REMU; otherwise those ops complete with rsp_err.
module muldiv_sequencer
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_err,
    output logic            busy,
    output logic [XLEN-1:0] alu_operand_a,
    output logic [XLEN-1:0] alu_operand_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_carry
);

    md_state_e       r_state, w_state_nxt;
    logic [2:0]      r_op;
    logic            r_sa, r_sb, r_err;
    logic            w_accept, w_a_signed, w_b_signed, w_sa, w_sb;
    logic            w_special, w_err_req, w_neg, w_fix_rem, w_z;
    logic [XLEN-1:0] w_hi_init, w_lo_init, w_hi, w_lo, w_mcand, w_sel;
    logic [4:0]      w_cnt;

    assign w_accept   = req_valid & (r_state == ST_IDLE);
    assign w_a_signed = (req_op == F3_MULH) | (req_op == F3_MULHSU) | (req_op == F3_DIV) | (req_op == F3_REM);
    assign w_b_signed = (req_op == F3_MULH) | (req_op == F3_DIV) | (req_op == F3_REM);
    assign w_sa       = w_a_signed & req_a[XLEN-1];
    assign w_sb       = w_b_signed & req_b[XLEN-1];

`ifdef MULDIV_DIV_EN
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    logic w_div0, w_ovf;

    assign w_div0    = req_op[2] & (req_b == '0);
    assign w_ovf     = ((req_op == F3_DIV) | (req_op == F3_REM)) & (req_a == INT_MIN) & (req_b == '1);
    assign w_special = w_div0 | w_ovf;
    assign w_err_req = 1'b0;
    assign w_fix_rem = (r_op == F3_REM);

    // Special cases preload the final {rem, quo} and skip straight to DONE.
    always_comb begin
        w_hi_init = '0;
        w_lo_init = req_a;
        if (w_div0) begin
            w_hi_init = req_a;
            w_lo_init = '1;
        end else if (w_ovf) begin
            w_lo_init = INT_MIN;
        end
    end
`else
    assign w_special = 1'b0;
    assign w_err_req = req_op[2];
    assign w_fix_rem = 1'b0;
    assign w_hi_init = '0;
    assign w_lo_init = req_a;
`endif

    // Remainder takes the dividend's sign; everything else the product/quotient sign.
    assign w_neg = (r_op == F3_REM) ? r_sa : (r_sa ^ r_sb);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_special | w_err_req) w_state_nxt = ST_DONE;
                    else if (w_sa)             w_state_nxt = ST_NEG_A;
                    else if (w_sb)             w_state_nxt = ST_NEG_B;
                    else                       w_state_nxt = ST_ITER;
                end
            end
            ST_NEG_A:  w_state_nxt = r_sb ? ST_NEG_B : ST_ITER;
            ST_NEG_B:  w_state_nxt = ST_ITER;
            ST_ITER:   if (w_cnt == 5'd0) w_state_nxt = w_neg ? ST_FIX_LO : ST_DONE;
            ST_FIX_LO: w_state_nxt = r_op[2] ? ST_DONE : ST_FIX_HI;
            ST_FIX_HI: w_state_nxt = ST_DONE;
            ST_DONE:   if (rsp_ready) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op  <= req_op;
                r_sa  <= w_sa;
                r_sb  <= w_sb;
                r_err <= w_err_req;
            end
        end
    end

    always_comb begin
        alu_operand_a = '0;
        alu_operand_b = '0;
        alu_op        = OP_ADD;
        case (r_state)
            ST_NEG_A: begin
                alu_operand_b = w_lo;
                alu_op        = OP_SUB;
            end
            ST_NEG_B: begin
                alu_operand_b = w_mcand;
                alu_op        = OP_SUB;
            end
            ST_ITER: begin
`ifdef MULDIV_DIV_EN
                if (r_op[2]) begin
                    alu_operand_a = {w_hi[XLEN-2:0], w_lo[XLEN-1]};
                    alu_operand_b = w_mcand;
                    alu_op        = OP_SUB;
                end else
`endif
                begin
                    alu_operand_a = w_hi;
                    alu_operand_b = w_lo[0] ? w_mcand : '0;
                end
            end
            ST_FIX_LO: begin
                alu_operand_b = w_fix_rem ? w_hi : w_lo;
                alu_op        = OP_SUB;
            end
            ST_FIX_HI: begin
                // Carry from the low-word negate only propagates when the low word was zero.
                if (w_z) begin
                    alu_operand_b = w_hi;
                    alu_op        = OP_SUB;
                end else begin
                    alu_operand_a = w_hi;
                    alu_operand_b = '1;
                    alu_op        = OP_XOR;
                end
            end
            default: ;
        endcase
    end

    muldiv_iter_dp #(.XLEN(XLEN)) u_dp (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_accept),
        .i_hi_init    (w_hi_init),
        .i_lo_init    (w_lo_init),
        .i_mcand_init (req_b),
        .i_neg_a      (r_state == ST_NEG_A),
        .i_neg_b      (r_state == ST_NEG_B),
        .i_iter       (r_state == ST_ITER),
`ifdef MULDIV_DIV_EN
        .i_is_div     (r_op[2]),
`endif
        .i_fix_lo     (r_state == ST_FIX_LO),
        .i_fix_rem    (w_fix_rem),
        .i_fix_hi     (r_state == ST_FIX_HI),
        .i_alu_result (alu_result),
        .i_alu_carry  (alu_carry),
        .o_hi         (w_hi),
        .o_lo         (w_lo),
        .o_mcand      (w_mcand),
        .o_cnt        (w_cnt),
        .o_z          (w_z)
    );

    assign w_sel     = f3_sel_hi(r_op) ? w_hi : w_lo;
    assign rsp_valid = (r_state == ST_DONE);
    assign rsp_data  = (rsp_valid & ~r_err) ? w_sel : '0;
    assign rsp_err   = rsp_valid & r_err;
    assign busy      = (r_state != ST_IDLE);
    assign req_ready = (r_state == ST_IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M cases, backpressure, mid-op reset
// and random ops against an arithmetic reference model; divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_sequencer;

    localparam logic [2:0] T_MUL = 3'd0, T_MULH = 3'd1, T_MULHSU = 3'd2, T_MULHU = 3'd3;
    localparam logic [2:0] T_DIV = 3'd4, T_DIVU = 3'd5, T_REM = 3'd6, T_REMU = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [31:0] alu_operand_a, alu_operand_b, alu_result;
    logic [3:0]  alu_op;
    logic        alu_carry;

    int n_vec = 0;
    int n_err = 0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_a         (req_a),
        .req_b         (req_b),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .busy          (busy),
        .alu_operand_a (alu_operand_a),
        .alu_operand_b (alu_operand_b),
        .alu_op        (alu_op),
        .alu_result    (alu_result),
        .alu_carry     (alu_carry)
    );

    always #5 clk = ~clk;

    // Shared ALU: ADD carry-out, SUB borrow (a<b unsigned), XOR.
    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        case (alu_op)
            4'b0000: {alu_carry, alu_result} = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
            4'b0001: begin
                alu_result = alu_operand_a - alu_operand_b;
                alu_carry  = (alu_operand_a < alu_operand_b);
            end
            4'b0100: alu_result = alu_operand_a ^ alu_operand_b;
            default: ;
        endcase
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " rsp_data"}, rsp_data, 32'd0);
        chk({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " alu_a"}, alu_operand_a, 32'd0);
        chk({tag, " alu_b"}, alu_operand_b, 32'd0);
        chk({tag, " alu_op"}, 32'(alu_op), 32'd0);
    endtask

    // Reference: plain 64-bit / signed arithmetic plus latency from the visited fix-up states.
    task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] d, output logic e, output int lat);
        logic [63:0] p;
        logic        sa, sb, neg;
        d   = '0;
        e   = 1'b0;
        lat = 1;
        p   = '0;
        case (op)
            T_MUL:    begin p = {32'b0, a} * {32'b0, b}; d = p[31:0]; end
            T_MULH:   begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); d = p[63:32]; end
            T_MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b}; d = p[63:32]; end
            T_MULHU:  begin p = {32'b0, a} * {32'b0, b}; d = p[63:32]; end
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == 32'd0) d = op[1] ? a : 32'hFFFFFFFF;
                else if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) d = op[1] ? 32'd0 : 32'h80000000;
                else begin
                    case (op)
                        T_DIV:   d = $signed(a) / $signed(b);
                        T_DIVU:  d = a / b;
                        T_REM:   d = $signed(a) % $signed(b);
                        default: d = a % b;
                    endcase
                    lat = 0;
                end
`else
                e = 1'b1;
`endif
            end
        endcase
        if (!op[2] || lat == 0) begin
            sa  = (op == T_MULH || op == T_MULHSU || op == T_DIV || op == T_REM) && a[31];
            sb  = (op == T_MULH || op == T_DIV || op == T_REM) && b[31];
            neg = (op == T_REM) ? sa : (sa ^ sb);
            lat = 33 + int'(sa) + int'(sb) + (neg ? (op[2] ? 1 : 2) : 0);
        end
    endtask

    // Called at the falling edge right after the accept edge.
    task automatic wait_rsp(input string tag, input logic [31:0] ed, input logic ee, input int elat);
        int j;
        j = 0;
        while (!rsp_valid && j < 100) begin
            @(negedge clk);
            j++;
        end
        chk({tag, " latency"}, 32'(j + 1), 32'(elat));
        chk({tag, " data"}, rsp_data, ed);
        chk({tag, " err"}, 32'(rsp_err), 32'(ee));
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ed, input logic ee, input int elat);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        rsp_ready = 1'($urandom_range(0, 1));
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(tag, ed, ee, elat);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;
        int          seen;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;

        run_op("mulhu_ff", T_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33);
        run_op("mul_ff", T_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33);
        run_op("mul_m3x7", T_MUL, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 1'b0, 33);
        run_op("mulh_m3x7", T_MULH, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 1'b0, 36);
        run_op("mulhsu_ff", T_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 36);
`ifdef MULDIV_DIV_EN
        run_op("div_m7_2", T_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 35);
        run_op("rem_m7_2", T_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 35);
        run_op("divu_min_3", T_DIVU, 32'h80000000, 32'd3, 32'h2AAAAAAA, 1'b0, 33);
        run_op("divu_5_0", T_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b0, 1);
        run_op("remu_5_0", T_REMU, 32'd5, 32'd0, 32'd5, 1'b0, 1);
        run_op("div_ovf", T_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
        run_op("rem_ovf", T_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 1);
`else
        run_op("divu_5_0_off", T_DIVU, 32'd5, 32'd0, 32'd0, 1'b1, 1);
        run_op("rem_off", T_REM, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b1, 1);
`endif

        // Backpressure with the next request already waiting at the input.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = T_MULHU;
        req_a     = 32'hFFFFFFFF;
        req_b     = 32'hFFFFFFFF;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_op = T_MUL;
        req_a  = 32'd3;
        req_b  = 32'd5;
        wait_rsp("bp", 32'hFFFFFFFE, 1'b0, 33);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp hold valid", 32'(rsp_valid), 32'd1);
            chk("bp hold data", rsp_data, 32'hFFFFFFFE);
            chk("bp hold req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp idle req_ready", 32'(req_ready), 32'd1);
        chk("bp idle busy", 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp accept busy", 32'(busy), 32'd1);
        wait_rsp("bp next", 32'd15, 1'b0, 33);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset asserted while ITER's count is at 10.
        req_valid = 1'b1;
        req_op    = T_MULHU;
        req_a     = 32'h00010000;
        req_b     = 32'h00010000;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (21) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("iter_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid || busy) seen++;
        end
        chk("iter_rst no stale rsp", 32'(seen), 32'd0);
        run_op("mulhu_after_rst", T_MULHU, 32'h00010000, 32'h00010000, 32'h00000001, 1'b0, 33);

        for (int t = 0; t < 40; t++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            ref_op(op, a, b, d, e, lat);
            run_op($sformatf("rand%0d op%0d %h %h", t, op, a, b), op, a, b, d, e, lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
